// File: rtl/mem_access_ctrl.sv
// Burst load/store sequencer that is the only master of a 256x16 single-port data memory.
// Latency: a store word is written on the edge it is taken; a load word is returned READ_LAT+1 clocks after its address is presented.
// Backpressure: wr_valid low stalls a store; a request is held off until IDLE; rd_valid cannot be stalled.
module mem_access_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done,
    output logic              busy,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    beat_cnt;
    logic [LAT_W-1:0]    lat_cnt;

    // The write strobe is gated by state so an X on the data path never reaches it.
    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign wr_ready    = (state == WRITE);
    assign mem_enable  = (state == WRITE) && wr_valid;
    assign mem_address = cur_addr;
    assign mem_data_in = (state == WRITE) ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        beat_cnt <= req_len;
                        lat_cnt  <= '0;
                        state    <= req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Address has been stable for READ_LAT edges, so data_out is valid now.
                    if (lat_cnt == LAT_W'(READ_LAT)) begin
                        rd_data  <= mem_data_out;
                        rd_valid <= 1'b1;
                        rd_last  <= (beat_cnt == '0);
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        lat_cnt  <= '0;
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized store/load bursts against a behavioural memory and a closed-form timing model.
module tb_mem_access_ctrl;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, wr_valid;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [15:0] wr_data;
    logic        req_ready, wr_ready, rd_valid, rd_last, done, busy, mem_enable;
    logic [15:0] rd_data, mem_data_in, mem_data_out;
    logic [7:0]  mem_address;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] wbuf    [16];
    logic [7:0]  wq_a [$];
    logic [15:0] wq_d [$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .busy(busy),
        .mem_enable(mem_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Memory macro: write strobe and one-clock registered read.
    always @(posedge clk) begin
        if (mem_enable === 1'b1) begin
            mem[mem_address] <= mem_data_in;
            wq_a.push_back(mem_address);
            wq_d.push_back(mem_data_in);
        end
        mem_data_out <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_mem_enable"}, mem_enable, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_data_in"}, mem_data_in, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Entered and left on a negedge; stall_n cycles of wr_valid low precede beat stall_at.
    task automatic do_store(input logic [7:0] a, input int len, input int stall_at, input int stall_n);
        logic [7:0] ea;
        chk("st_idle_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = 4'(len);
        wq_a.delete(); wq_d.delete();
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'($urandom);
        chk("st_busy", busy, 1);
        chk("st_wr_ready", wr_ready, 1);
        chk("st_req_ready", req_ready, 0);
        for (int i = 0; i <= len; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    wr_valid = 1'b0; wr_data = 'x;
                    #1 chk("st_stall_enable", mem_enable, 0);
                    @(negedge clk);
                end
            end
            wr_valid = 1'b1; wr_data = wbuf[i];
            #1 chk("st_enable", mem_enable, 1);
            chk("st_mem_data_in", mem_data_in, wbuf[i]);
            @(negedge clk);
        end
        wr_valid = 1'b0; wr_data = 'x;
        chk("st_done", done, 1);
        chk("st_end_ready", req_ready, 1);
        chk("st_end_enable", mem_enable, 0);
        @(negedge clk);
        chk("st_done_pulse", done, 0);
        chk("st_strobe_count", wq_a.size(), len + 1);
        for (int i = 0; i <= len && i < wq_a.size(); i++) begin
            ea = a + 8'(i);
            chk("st_strobe_addr", wq_a[i], ea);
            chk("st_strobe_data", wq_d[i], wbuf[i]);
        end
        for (int i = 0; i <= len; i++) ref_mem[8'(a + 8'(i))] = wbuf[i];
    endtask

    // Beat b is expected (b+1)*(RL+1) negedges after the accepting edge.
    task automatic do_load(input logic [7:0] a, input int len, input int kill_after,
                           input bit hold, input logic [7:0] other);
        int total, b;
        bit v_exp;
        total = (len + 1) * (RL + 1);
        chk("ld_idle_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 4'(len);
        @(negedge clk);
        if (hold) begin
            req_addr = other; req_len = 4'd0;
        end else begin
            req_valid = 1'b0;
        end
        for (int n = 0; n <= total; n++) begin
            v_exp = (n > 0) && (n % (RL + 1) == 0);
            b = n / (RL + 1) - 1;
            chk("ld_rd_valid", rd_valid, v_exp);
            chk("ld_busy", busy, n < total);
            chk("ld_req_ready", req_ready, n == total);
            chk("ld_enable", mem_enable, 0);
            if (v_exp) begin
                chk("ld_rd_data", rd_data, ref_mem[8'(a + 8'(b))]);
                chk("ld_rd_last", rd_last, b == len);
                chk("ld_done", done, b == len);
            end else begin
                chk("ld_done_idle", done, 0);
            end
            if (v_exp && b == kill_after) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs("kill");
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    chk("kill_no_valid", rd_valid, 0);
                    chk("kill_no_done", done, 0);
                    chk("kill_idle", busy, 0);
                    @(negedge clk);
                end
                return;
            end
            if (n < total) @(negedge clk);
        end
    endtask

    initial begin
        int len, k;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h5A; req_len = 4'h3;
        wr_valid = 1'b0; wr_data = 'x;
        #3 chk_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wbuf[0] = 16'h0001;
        do_store(8'h01, 0, -1, 0);
        do_load(8'h01, 0, -1, 1'b0, 8'h00);

        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB; wbuf[2] = 16'hCCCC;
        do_store(8'hAA, 2, 1, 2);
        do_load(8'hAA, 2, -1, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
        do_store(8'hFE, 3, -1, 0);
        do_load(8'hFE, 3, -1, 1'b0, 8'h00);

        // Competing request held during a burst must wait for IDLE.
        do_load(8'hAA, 2, -1, 1'b1, 8'h00);
        @(negedge clk);
        chk("rej_accepted", busy, 1);
        chk("rej_address", mem_address, 8'h00);
        req_valid = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (rd_valid === 1'b1) break;
            @(negedge clk);
        end
        chk("rej_rd_seen", k < 10, 1);
        chk("rej_rd_data", rd_data, ref_mem[0]);
        chk("rej_done", done, 1);
        @(negedge clk);
        chk("rej_idle", req_ready, 1);

        do_load(8'hFE, 3, 1, 1'b0, 8'h00);
        do_load(8'hAA, 2, -1, 1'b0, 8'h00);

        for (int r = 0; r < 8; r++) begin
            a = 8'($urandom);
            len = $urandom_range(0, 5);
            for (int i = 0; i <= len; i++) wbuf[i] = 16'($urandom);
            do_store(a, len, $urandom_range(0, len + 1), $urandom_range(1, 3));
            do_load(a, len, -1, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
